// File: rtl/vr_commit_walker_if.sv
// Bundle of every signal between the VR commit walker and its surroundings:
// message manager, VR state store and the ring-buffered log header memory.
// master = the commit engine, slave = the environment around it.
interface vr_commit_walker_if #(
  parameter int OP_NUM_W  = 64,
  parameter int VIEW_W    = 64,
  parameter int LOG_IDX_W = 10
);
  // Commit message from the message manager
  logic                 msg_val;
  logic                 msg_rdy;
  logic [OP_NUM_W-1:0]  msg_commit_num;
  logic [VIEW_W-1:0]    msg_view;

  // VR state store: current values and commit-point write-back
  logic [OP_NUM_W-1:0]  state_commit_num;
  logic [VIEW_W-1:0]    state_view;
  logic                 state_wr_val;
  logic                 state_wr_rdy;
  logic [OP_NUM_W-1:0]  state_wr_commit_num;

  // Log header memory: read request / response
  logic                 rd_req_val;
  logic                 rd_req_rdy;
  logic [LOG_IDX_W-1:0] rd_req_addr;
  logic                 rd_resp_val;
  logic                 rd_resp_rdy;
  logic [OP_NUM_W-1:0]  rd_resp_op_num;
  logic [VIEW_W-1:0]    rd_resp_view;
  logic                 rd_resp_committed;

  // Log header memory: write
  logic                 wr_val;
  logic                 wr_rdy;
  logic [LOG_IDX_W-1:0] wr_addr;
  logic [OP_NUM_W-1:0]  wr_op_num;
  logic [VIEW_W-1:0]    wr_view;
  logic                 wr_committed;

  // Status
  logic                 eng_rdy;
  logic [31:0]          stat_commits;
  logic [31:0]          stat_stalls;

  modport master (
    input  msg_val, msg_commit_num, msg_view,
    output msg_rdy,
    input  state_commit_num, state_view, state_wr_rdy,
    output state_wr_val, state_wr_commit_num,
    input  rd_req_rdy, rd_resp_val, rd_resp_op_num, rd_resp_view, rd_resp_committed,
    output rd_req_val, rd_req_addr, rd_resp_rdy,
    input  wr_rdy,
    output wr_val, wr_addr, wr_op_num, wr_view, wr_committed,
    output eng_rdy, stat_commits, stat_stalls
  );

  modport slave (
    output msg_val, msg_commit_num, msg_view,
    input  msg_rdy,
    output state_commit_num, state_view, state_wr_rdy,
    input  state_wr_val, state_wr_commit_num,
    output rd_req_rdy, rd_resp_val, rd_resp_op_num, rd_resp_view, rd_resp_committed,
    input  rd_req_val, rd_req_addr, rd_resp_rdy,
    output wr_rdy,
    input  wr_val, wr_addr, wr_op_num, wr_view, wr_committed,
    input  eng_rdy, stat_commits, stat_stalls
  );
endinterface

// File: rtl/vr_commit_walker.sv
// VR commit walker: on a commit message, walks the ring-buffered log headers
// from the last committed op up to the requested op, marks each matching
// header committed and writes the commit point back to VR state, with
// intermediate checkpoints every MAX_BATCH entries and partial-progress
// commit when a header does not match.
// Optional feature: define VR_COMMIT_STATS_EN for live saturating
// stat_commits / stat_stalls counters; otherwise both read as 0.
module vr_commit_walker #(
  parameter int OP_NUM_W  = 64,
  parameter int VIEW_W    = 64,
  parameter int LOG_IDX_W = 10,
  parameter int MAX_BATCH = 16
) (
  input  logic                clk,
  input  logic                rst,
  vr_commit_walker_if.master  bus
);

  localparam int BATCH_W = $clog2(MAX_BATCH) + 1;
  localparam logic [BATCH_W-1:0]  BATCH_LAST = BATCH_W'(MAX_BATCH - 1);
  // Number of entries the ring can hold; a single walk never spans more.
  localparam logic [OP_NUM_W-1:0] RING = OP_NUM_W'(1) << LOG_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_ENTRY,
    WR_STATE
  } state_t;

  state_t               state_q;

  // Walk context
  logic [OP_NUM_W-1:0]  start_q;
  logic [OP_NUM_W-1:0]  cur_q;
  logic [OP_NUM_W-1:0]  target_q;
  logic [VIEW_W-1:0]    view_q;
  logic [BATCH_W-1:0]   batch_q;
  logic                 final_q;
  logic                 hdr_ok_q;
  logic                 hdr_committed_q;

  // Registered outputs
  logic                 msg_rdy_q;
  logic                 rd_req_val_q;
  logic [LOG_IDX_W-1:0] rd_req_addr_q;
  logic                 rd_resp_rdy_q;
  logic                 wr_val_q;
  logic [LOG_IDX_W-1:0] wr_addr_q;
  logic [OP_NUM_W-1:0]  wr_op_q;
  logic [VIEW_W-1:0]    wr_view_q;
  logic                 state_wr_val_q;
  logic [OP_NUM_W-1:0]  state_wr_num_q;

  // Datapath helpers
  logic [OP_NUM_W-1:0]  first_op;
  logic [OP_NUM_W-1:0]  cur_next;
  logic [OP_NUM_W-1:0]  span;
  logic [OP_NUM_W-1:0]  clamp_target;
  logic                 stale;
  logic                 resp_ok;
  logic                 at_target;
  logic                 batch_full;

  assign first_op     = bus.state_commit_num + 1'b1;
  assign cur_next     = cur_q + 1'b1;
  assign span         = bus.msg_commit_num - bus.state_commit_num;
  assign clamp_target = (span > RING) ? (bus.state_commit_num + RING) : bus.msg_commit_num;
  assign stale        = (bus.msg_view != bus.state_view) ||
                        (bus.msg_commit_num <= bus.state_commit_num);
  // The header match is evaluated as the response arrives so that the
  // write request can come out of a register in WR_ENTRY.
  assign resp_ok      = (bus.rd_resp_op_num == cur_q) && (bus.rd_resp_view == view_q);
  assign at_target    = (cur_q == target_q);
  assign batch_full   = (batch_q == BATCH_LAST);

  // Walk FSM: state, walk context and every handshake output in one place
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and all state uses <=, so every
    // register in this block updates together from the pre-edge values.
    if (!rst) begin
      state_q         <= IDLE;
      start_q         <= '0;
      cur_q           <= '0;
      target_q        <= '0;
      view_q          <= '0;
      batch_q         <= '0;
      final_q         <= 1'b0;
      hdr_ok_q        <= 1'b0;
      hdr_committed_q <= 1'b0;
      msg_rdy_q       <= 1'b0;
      rd_req_val_q    <= 1'b0;
      rd_req_addr_q   <= '0;
      rd_resp_rdy_q   <= 1'b0;
      wr_val_q        <= 1'b0;
      wr_addr_q       <= '0;
      wr_op_q         <= '0;
      wr_view_q       <= '0;
      state_wr_val_q  <= 1'b0;
      state_wr_num_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          msg_rdy_q <= 1'b1;
          if (bus.msg_val && msg_rdy_q) begin
            start_q  <= bus.state_commit_num;
            cur_q    <= first_op;
            target_q <= clamp_target;
            view_q   <= bus.msg_view;
            batch_q  <= '0;
            // Stale or foreign messages are consumed without leaving IDLE.
            if (!stale) begin
              state_q       <= RD_REQ;
              msg_rdy_q     <= 1'b0;
              rd_req_val_q  <= 1'b1;
              rd_req_addr_q <= first_op[LOG_IDX_W-1:0];
            end
          end
        end

        RD_REQ: begin
          if (bus.rd_req_rdy) begin
            rd_req_val_q  <= 1'b0;
            rd_resp_rdy_q <= 1'b1;
            state_q       <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.rd_resp_val) begin
            rd_resp_rdy_q   <= 1'b0;
            hdr_ok_q        <= resp_ok;
            hdr_committed_q <= bus.rd_resp_committed;
            wr_val_q        <= resp_ok && !bus.rd_resp_committed;
            wr_addr_q       <= cur_q[LOG_IDX_W-1:0];
            wr_op_q         <= cur_q;
            wr_view_q       <= view_q;
            state_q         <= WR_ENTRY;
          end
        end

        WR_ENTRY: begin
          if (!hdr_ok_q) begin
            // Mismatch: keep whatever progress was made before this entry.
            if (cur_q > start_q + 1'b1) begin
              state_wr_val_q <= 1'b1;
              state_wr_num_q <= cur_q - 1'b1;
              final_q        <= 1'b1;
              state_q        <= WR_STATE;
            end else begin
              msg_rdy_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (!wr_val_q || bus.wr_rdy) begin
            wr_val_q <= 1'b0;
            if (at_target) begin
              state_wr_val_q <= 1'b1;
              state_wr_num_q <= cur_q;
              final_q        <= 1'b1;
              state_q        <= WR_STATE;
            end else begin
              cur_q <= cur_next;
              if (batch_full) begin
                // Checkpoint the entry just finished, then resume the walk.
                batch_q        <= '0;
                state_wr_val_q <= 1'b1;
                state_wr_num_q <= cur_q;
                final_q        <= 1'b0;
                state_q        <= WR_STATE;
              end else begin
                batch_q       <= batch_q + 1'b1;
                rd_req_val_q  <= 1'b1;
                rd_req_addr_q <= cur_next[LOG_IDX_W-1:0];
                state_q       <= RD_REQ;
              end
            end
          end
        end

        WR_STATE: begin
          if (bus.state_wr_rdy) begin
            state_wr_val_q <= 1'b0;
            if (final_q) begin
              msg_rdy_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              rd_req_val_q  <= 1'b1;
              rd_req_addr_q <= cur_q[LOG_IDX_W-1:0];
              state_q       <= RD_REQ;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.msg_rdy             = msg_rdy_q;
  assign bus.eng_rdy             = msg_rdy_q;
  assign bus.rd_req_val          = rd_req_val_q;
  assign bus.rd_req_addr         = rd_req_addr_q;
  assign bus.rd_resp_rdy         = rd_resp_rdy_q;
  assign bus.wr_val              = wr_val_q;
  assign bus.wr_addr             = wr_addr_q;
  assign bus.wr_op_num           = wr_op_q;
  assign bus.wr_view             = wr_view_q;
  assign bus.wr_committed        = 1'b1;
  assign bus.state_wr_val        = state_wr_val_q;
  assign bus.state_wr_commit_num = state_wr_num_q;

`ifdef VR_COMMIT_STATS_EN
  logic [31:0] commits_q;
  logic [31:0] stalls_q;
  logic        commit_evt;
  logic        stall_evt;

  assign commit_evt = (state_q == WR_ENTRY) && wr_val_q && bus.wr_rdy;
  assign stall_evt  = (state_q == WR_ENTRY) && !hdr_ok_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      commits_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (commit_evt && (commits_q != '1)) commits_q <= commits_q + 1'b1;
      if (stall_evt && (stalls_q != '1))   stalls_q  <= stalls_q + 1'b1;
    end
  end

  assign bus.stat_commits = commits_q;
  assign bus.stat_stalls  = stalls_q;
`else
  assign bus.stat_commits = '0;
  assign bus.stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_vr_commit_walker.sv
// Self-checking bench for vr_commit_walker: a header-memory model and a VR
// state sink answer the engine; expected reads, header writes and state
// writes are queued when each message is sent and popped as the DUT emits them.
module tb_vr_commit_walker;

  localparam int OP_W = 16;
  localparam int VW   = 8;
  localparam int IW   = 4;
  localparam int MB   = 4;
  localparam int RING = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vr_commit_walker_if #(.OP_NUM_W(OP_W), .VIEW_W(VW), .LOG_IDX_W(IW)) bus ();

  vr_commit_walker #(
    .OP_NUM_W(OP_W), .VIEW_W(VW), .LOG_IDX_W(IW), .MAX_BATCH(MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Header memory model
  logic [OP_W-1:0] mem_op   [RING];
  logic [VW-1:0]   mem_view [RING];
  logic            mem_cm   [RING];

  // Scoreboard
  logic [IW-1:0]      exp_rd [$];
  logic [IW+OP_W-1:0] exp_wr [$];
  logic [OP_W-1:0]    exp_st [$];

  int          n_rd = 0, n_wr = 0, n_st = 0;
  bit          bp_en = 1'b0;
  bit          resp_hold = 1'b0;
  logic [VW-1:0] cur_view = '0;
  int          exp_commits = 0, exp_stalls = 0;

  task automatic hdr(input logic [OP_W-1:0] op, input logic [VW-1:0] v, input logic cm);
    mem_op[op[IW-1:0]]   = op;
    mem_view[op[IW-1:0]] = v;
    mem_cm[op[IW-1:0]]   = cm;
  endtask

  task automatic exp_entry(input logic [OP_W-1:0] op, input bit writes);
    exp_rd.push_back(op[IW-1:0]);
    if (writes) exp_wr.push_back({op[IW-1:0], op});
  endtask

  // Header read responder
  initial begin
    logic [IW-1:0] a;
    int k;
    bus.rd_req_rdy        = 1'b0;
    bus.rd_resp_val       = 1'b0;
    bus.rd_resp_op_num    = '0;
    bus.rd_resp_view      = '0;
    bus.rd_resp_committed = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_req_rdy = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst && bus.rd_req_val && bus.rd_req_rdy) begin
        a = bus.rd_req_addr;
        n_rd++;
        if (exp_rd.size() == 0) check("rd_unexpected", exp_rd.size(), 1);
        else check("rd_addr", a, exp_rd.pop_front());
        @(posedge clk);
        if (!resp_hold) begin
          if (bp_en) repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          bus.rd_resp_val       = 1'b1;
          bus.rd_resp_op_num    = mem_op[a];
          bus.rd_resp_view      = mem_view[a];
          bus.rd_resp_committed = mem_cm[a];
          k = 0;
          @(negedge clk);
          while (!bus.rd_resp_rdy && k < 100) begin k++; @(negedge clk); end
          if (k == 100) check("rd_resp_handshake", bus.rd_resp_rdy, 1);
          @(posedge clk);
          #1 bus.rd_resp_val = 1'b0;
        end
      end
    end
  end

  // Header write sink
  initial begin
    logic [IW+OP_W-1:0] e;
    bus.wr_rdy = 1'b0;
    forever begin
      @(negedge clk);
      bus.wr_rdy = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst && bus.wr_val && bus.wr_rdy) begin
        n_wr++;
        if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", bus.wr_addr, e[IW+OP_W-1:OP_W]);
          check("wr_op", bus.wr_op_num, e[OP_W-1:0]);
        end
        check("wr_view", bus.wr_view, cur_view);
        check("wr_committed", bus.wr_committed, 1);
        mem_cm[bus.wr_addr] = 1'b1;
      end
    end
  end

  // VR state write sink
  initial begin
    bus.state_wr_rdy = 1'b0;
    forever begin
      @(negedge clk);
      bus.state_wr_rdy = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst && bus.state_wr_val && bus.state_wr_rdy) begin
        n_st++;
        if (exp_st.size() == 0) check("st_unexpected", exp_st.size(), 1);
        else check("st_commit_num", bus.state_wr_commit_num, exp_st.pop_front());
      end
    end
  end

  task automatic check_stats(input string tag);
`ifdef VR_COMMIT_STATS_EN
    check({tag, "_stat_commits"}, bus.stat_commits, exp_commits);
    check({tag, "_stat_stalls"}, bus.stat_stalls, exp_stalls);
`else
    check({tag, "_stat_commits"}, bus.stat_commits, 0);
    check({tag, "_stat_stalls"}, bus.stat_stalls, 0);
`endif
  endtask

  task automatic send_msg(input logic [OP_W-1:0] sc, input logic [VW-1:0] sv,
                          input logic [OP_W-1:0] mc, input logic [VW-1:0] mv);
    int k;
    @(negedge clk);
    bus.state_commit_num = sc;
    bus.state_view       = sv;
    bus.msg_commit_num   = mc;
    bus.msg_view         = mv;
    bus.msg_val          = 1'b1;
    k = 0;
    while (!bus.msg_rdy && k < 100) begin k++; @(negedge clk); end
    if (k == 100) check("msg_rdy_wait", bus.msg_rdy, 1);
    @(posedge clk);
    #1 bus.msg_val = 1'b0;
  endtask

  // Counts cycles the engine stays busy after the accepting edge
  task automatic wait_idle(output int busy);
    busy = 0;
    @(negedge clk);
    while (!bus.eng_rdy && busy < 3000) begin busy++; @(negedge clk); end
    if (busy == 3000) check("idle_wait", bus.eng_rdy, 1);
  endtask

  task automatic run(input string tag,
                     input logic [OP_W-1:0] sc, input logic [VW-1:0] sv,
                     input logic [OP_W-1:0] mc, input logic [VW-1:0] mv,
                     input int busy_exp, input int rd_n, input int wr_n, input int st_n);
    int rd0, wr0, st0, busy;
    rd0 = n_rd; wr0 = n_wr; st0 = n_st;
    send_msg(sc, sv, mc, mv);
    wait_idle(busy);
    if (busy_exp >= 0) check({tag, "_busy"}, busy, busy_exp);
    check({tag, "_rd_count"}, n_rd - rd0, rd_n);
    check({tag, "_wr_count"}, n_wr - wr0, wr_n);
    check({tag, "_st_count"}, n_st - st0, st_n);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_st_left"}, exp_st.size(), 0);
    check_stats(tag);
    exp_rd.delete();
    exp_wr.delete();
    exp_st.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rd0, wr0, st0;
    bus.msg_val          = 1'b0;
    bus.msg_commit_num   = '0;
    bus.msg_view         = '0;
    bus.state_commit_num = '0;
    bus.state_view       = '0;
    for (int i = 0; i < RING; i++) hdr(OP_W'(i), '0, 1'b0);

    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_msg_rdy", bus.msg_rdy, 0);
    check("rst_eng_rdy", bus.eng_rdy, 0);
    check("rst_rd_req_val", bus.rd_req_val, 0);
    check("rst_rd_resp_rdy", bus.rd_resp_rdy, 0);
    check("rst_wr_val", bus.wr_val, 0);
    check("rst_state_wr_val", bus.state_wr_val, 0);
    check("rst_rd_req_addr", bus.rd_req_addr, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_op", bus.wr_op_num, 0);
    check("rst_state_wr_num", bus.state_wr_commit_num, 0);
    check_stats("rst");
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_eng_rdy", bus.eng_rdy, 1);
    check("post_rst_msg_rdy", bus.msg_rdy, 1);

    // Basic walk 6..8: 3 cycles per entry + 1 state write
    cur_view = 8'd3;
    for (int op = 6; op <= 8; op++) begin hdr(OP_W'(op), 8'd3, 1'b0); exp_entry(OP_W'(op), 1'b1); end
    exp_st.push_back(16'd8);
    exp_commits += 3;
    run("basic", 16'd5, 8'd3, 16'd8, 8'd3, 10, 3, 3, 1);

    // Stale and foreign messages are consumed with no traffic
    run("stale_eq", 16'd8, 8'd3, 16'd8, 8'd3, 0, 0, 0, 0);
    run("stale_lt", 16'd8, 8'd3, 16'd7, 8'd3, 0, 0, 0, 0);
    run("foreign", 16'd8, 8'd3, 16'd10, 8'd4, 0, 0, 0, 0);

    // Batched checkpoints at 4 and 8, final at 10
    cur_view = 8'd5;
    for (int op = 1; op <= 10; op++) begin hdr(OP_W'(op), 8'd5, 1'b0); exp_entry(OP_W'(op), 1'b1); end
    exp_st.push_back(16'd4); exp_st.push_back(16'd8); exp_st.push_back(16'd10);
    exp_commits += 10;
    run("batch", 16'd0, 8'd5, 16'd10, 8'd5, 33, 10, 10, 3);

    // Ring wrap: ops 15,16,17 live at indices 15,0,1
    cur_view = 8'd2;
    for (int op = 15; op <= 17; op++) begin hdr(OP_W'(op), 8'd2, 1'b0); exp_entry(OP_W'(op), 1'b1); end
    exp_st.push_back(16'd17);
    exp_commits += 3;
    run("wrap", 16'd14, 8'd2, 16'd17, 8'd2, 10, 3, 3, 1);

    // Clamp: request 30 from 2 is limited to one ring (target 18)
    cur_view = 8'd1;
    for (int op = 3; op <= 18; op++) begin hdr(OP_W'(op), 8'd1, 1'b0); exp_entry(OP_W'(op), 1'b1); end
    exp_st.push_back(16'd6); exp_st.push_back(16'd10);
    exp_st.push_back(16'd14); exp_st.push_back(16'd18);
    exp_commits += 16;
    run("clamp", 16'd2, 8'd1, 16'd30, 8'd1, 52, 16, 16, 4);

    // Mismatch at op 7: op 6 committed, partial state write of 6
    cur_view = 8'd3;
    hdr(16'd6, 8'd3, 1'b0);
    hdr(16'd7, 8'd3, 1'b0); mem_op[7] = 16'd3;
    exp_entry(16'd6, 1'b1); exp_entry(16'd7, 1'b0);
    exp_st.push_back(16'd6);
    exp_commits += 1; exp_stalls += 1;
    run("mismatch", 16'd5, 8'd3, 16'd9, 8'd3, 7, 2, 1, 1);

    // First-entry mismatch (wrong view): nothing written
    hdr(16'd6, 8'd7, 1'b0);
    exp_entry(16'd6, 1'b0);
    exp_stalls += 1;
    run("first_mismatch", 16'd5, 8'd3, 16'd9, 8'd3, 3, 1, 0, 0);

    // Reset while waiting in RD_RESP abandons the walk
    for (int op = 6; op <= 8; op++) hdr(OP_W'(op), 8'd3, 1'b0);
    exp_rd.push_back(4'd6);
    rd0 = n_rd; wr0 = n_wr; st0 = n_st;
    resp_hold = 1'b1;
    send_msg(16'd5, 8'd3, 16'd8, 8'd3);
    k = 0;
    @(negedge clk);
    while (!bus.rd_resp_rdy && k < 50) begin k++; @(negedge clk); end
    check("rstmid_in_rd_resp", bus.rd_resp_rdy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_rd_resp_rdy", bus.rd_resp_rdy, 0);
    check("rstmid_rd_req_val", bus.rd_req_val, 0);
    check("rstmid_state_wr_val", bus.state_wr_val, 0);
    exp_commits = 0; exp_stalls = 0;
    check_stats("rstmid");
    rst = 1'b1;
    resp_hold = 1'b0;
    @(negedge clk);
    check("rstmid_eng_rdy", bus.eng_rdy, 1);
    repeat (3) @(negedge clk);
    check("rstmid_rd_count", n_rd - rd0, 1);
    check("rstmid_wr_count", n_wr - wr0, 0);
    check("rstmid_st_count", n_st - st0, 0);
    check("rstmid_rd_left", exp_rd.size(), 0);

    // Already-committed header 6 is skipped, 7 is written
    hdr(16'd6, 8'd3, 1'b1);
    hdr(16'd7, 8'd3, 1'b0);
    exp_entry(16'd6, 1'b0); exp_entry(16'd7, 1'b1);
    exp_st.push_back(16'd7);
    exp_commits += 1;
    run("skip_committed", 16'd5, 8'd3, 16'd7, 8'd3, 7, 2, 1, 1);

    // Random backpressure on every ready and on the read response
    bp_en = 1'b1;
    cur_view = 8'd9;
    for (int op = 1; op <= 6; op++) begin hdr(OP_W'(op), 8'd9, 1'b0); exp_entry(OP_W'(op), 1'b1); end
    exp_st.push_back(16'd4); exp_st.push_back(16'd6);
    exp_commits += 6;
    run("backpressure", 16'd0, 8'd9, 16'd6, 8'd9, -1, 6, 6, 2);
    bp_en = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
